inst_rom: RTL and testbench

//  Instruction memory serving the cpu fetch port: takes the byte address the core drives on addr_rom_o
//  and returns the instruction word on its data_rom_i, READ_LAT cycles later, fully pipelined.

---
 rtl/inst_rom.sv | 105 ++++++++++
 tb/tb_inst_rom.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom.sv
// Instruction ROM for the cpu fetch port with a boot-time loader write port and a fetch counter.
// Latency: READ_LAT clock edges from the sampled request to the registered result (1..4), fully pipelined.
// Backpressure: none; one request per cycle and never stalls. Optional INST_ROM_ALIGN_CHK_EN faults misaligned fetches.
module inst_rom #(
  parameter int          ADDR_W    = 10,
  parameter int          READ_LAT  = 1,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  output logic              err_o,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       fetch_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  // Program storage; deliberately not reset so a downloaded program survives a core reset.
  logic [31:0] mem [DEPTH];

  // Pipeline stage 0 holds the array read; later stages only delay it.
  logic [READ_LAT-1:0] p_vld;
  logic [READ_LAT-1:0] p_err;
  logic [31:0]         p_dat [READ_LAT];
  logic [31:0]         held_q;
  logic                last_nxt;

  logic [ADDR_W-1:0] idx;
  logic              range_flt;
  logic              align_flt;
  logic              fault;

  assign idx       = addr_i[ADDR_W+1:2];
  // Any set bit above the array span is a fault; addresses never alias back into the array.
  assign range_flt = |addr_i[31:ADDR_W+2];

`ifdef INST_ROM_ALIGN_CHK_EN
  assign align_flt = |addr_i[1:0];
`else
  // Byte offset is ignored: a misaligned fetch returns the containing word.
  assign align_flt = 1'b0;
  logic unused_addr_lo;
  assign unused_addr_lo = &{1'b0, addr_i[1:0]};
`endif

  assign fault = range_flt | align_flt;

  // Valid bit arriving at the output stage on the coming edge, used to advance the counter.
  if (READ_LAT == 1) begin : g_lat1
    assign last_nxt = ce;
  end else begin : g_latn
    assign last_nxt = p_vld[READ_LAT-2];
  end

  // Loader write port; the fetch read below sees the old word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Data path: read (or substitute NOP on fault) in stage 0, then shift toward the output.
  always_ff @(posedge clk) begin
    p_dat[0] <= fault ? NOP_WORD : mem[idx];
    for (int i = 1; i < READ_LAT; i++) begin
      p_dat[i] <= p_dat[i-1];
    end
  end

  // Control path: valid/err shift, last-presented data capture and fetch counter, all cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld     <= '0;
      p_err     <= '0;
      held_q    <= NOP_WORD;
      fetch_cnt <= 32'd0;
    end else begin
      p_vld[0] <= ce;
      p_err[0] <= fault;
      for (int i = 1; i < READ_LAT; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_err[i] <= p_err[i-1];
      end
      held_q <= data_o;
      if (last_nxt) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  // Bubbles keep showing the previous result; held_q tracks whatever was last on data_o.
  always_comb begin
    valid_o = p_vld[READ_LAT-1];
    err_o   = p_vld[READ_LAT-1] & p_err[READ_LAT-1];
    data_o  = p_vld[READ_LAT-1] ? p_dat[READ_LAT-1] : held_q;
  end

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;

  localparam int          AW  = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [31:0]   addr;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [31:0]   d1, d3, c1, c3;
  logic          v1, v3, e1, e3;

  always #5 clk = ~clk;

  inst_rom #(.ADDR_W(AW), .READ_LAT(1), .NOP_WORD(NOP)) u_rom1 (
    .clk(clk), .rst(rst), .ce(ce), .addr_i(addr), .data_o(d1), .valid_o(v1), .err_o(e1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(c1));

  inst_rom #(.ADDR_W(AW), .READ_LAT(3), .NOP_WORD(NOP)) u_rom3 (
    .clk(clk), .rst(rst), .ce(ce), .addr_i(addr), .data_o(d3), .valid_o(v3), .err_o(e3),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(c3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word memory plus a time-indexed schedule of results per DUT.
  logic [31:0] mem_m [1 << AW];
  int          cyc = 0;
  int          lat [2] = '{1, 3};
  bit          sv [2][0:4095];
  bit          se [2][0:4095];
  logic [31:0] sd [2][0:4095];
  logic [31:0] held [2];
  logic [31:0] cnt [2];
  bit          ev [2];
  bit          ee [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 6; j++) sv[d][cyc+j] = 1'b0;
      ev[d] = 1'b0; ee[d] = 1'b0; held[d] = NOP; cnt[d] = 32'd0;
    end
  endtask

  task automatic model_edge();
    bit f;
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ce) begin
          f = (addr >= (32'd1 << (AW + 2)));
`ifdef INST_ROM_ALIGN_CHK_EN
          f = f || (addr % 4 != 0);
`endif
          sv[d][cyc+lat[d]-1] = 1'b1;
          se[d][cyc+lat[d]-1] = f;
          sd[d][cyc+lat[d]-1] = f ? NOP : mem_m[(addr / 4) % (1 << AW)];
        end
      end
      for (int d = 0; d < 2; d++) begin
        ev[d] = sv[d][cyc];
        ee[d] = se[d][cyc];
        if (ev[d]) begin
          held[d] = sd[d][cyc];
          cnt[d]  = cnt[d] + 32'd1;
        end
        sv[d][cyc] = 1'b0;
      end
      if (ld_we) mem_m[ld_addr] = ld_data;
    end
  endtask

  task automatic compare_all();
    check("m_valid1", v1, ev[0]);
    check("m_data1", d1, held[0]);
    if (ev[0]) check("m_err1", e1, ee[0]);
    check("m_cnt1", c1, cnt[0]);
    check("m_valid3", v3, ev[1]);
    check("m_data3", d3, held[1]);
    if (ev[1]) check("m_err3", e3, ee[1]);
    check("m_cnt3", c3, cnt[1]);
  endtask

  task automatic step(input bit c, input logic [31:0] a, input bit w = 1'b0,
                      input logic [AW-1:0] la = '0, input logic [31:0] ld = 32'd0);
    ce = c; addr = a; ld_we = w; ld_addr = la; ld_data = ld;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    bit            c;
    logic [31:0]   a;
    bit            w;
    logic [AW-1:0] la;
    logic [31:0]   ld;
    bit            exp_v;
    logic [31:0]   exp_d;
    bit            exp_e;
    logic [31:0]   exp_cnt;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ce = 1'b0; addr = 32'd0; ld_we = 1'b0; ld_addr = '0; ld_data = 32'd0;
    model_reset();
    step(1'b1, 32'd0);
    step(1'b1, 32'd4);
    check("rst_valid", v1, 0); check("rst_data", d1, NOP); check("rst_cnt", c3, 0);
    rst = 1'b1;

    // Program download.
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: step(1'b0, 32'd0, 1'b1, AW'(i), 32'h11);
        1: step(1'b0, 32'd0, 1'b1, AW'(i), 32'h22);
        2: step(1'b0, 32'd0, 1'b1, AW'(i), 32'h33);
        3: step(1'b0, 32'd0, 1'b1, AW'(i), 32'h44);
        default: step(1'b0, 32'd0, 1'b1, AW'(i), 32'hA000_0000 + 32'(i));
      endcase
    end
    step(1'b0, 32'd0, 1'b1, AW'(1023), 32'hDEAD_BEEF);

    // Directed vectors against the READ_LAT=1 instance.
    tbl.push_back('{1'b1, 32'h0,         1'b0, '0, 0, 1'b1, 32'h11, 1'b0, 1});
    tbl.push_back('{1'b1, 32'h4,         1'b0, '0, 0, 1'b1, 32'h22, 1'b0, 2});
    tbl.push_back('{1'b1, 32'h8,         1'b0, '0, 0, 1'b1, 32'h33, 1'b0, 3});
    tbl.push_back('{1'b1, 32'hC,         1'b0, '0, 0, 1'b1, 32'h44, 1'b0, 4});
    tbl.push_back('{1'b0, 32'h0,         1'b0, '0, 0, 1'b0, 32'h44, 1'b0, 4});
    tbl.push_back('{1'b1, 32'h0,         1'b0, '0, 0, 1'b1, 32'h11, 1'b0, 5});
    tbl.push_back('{1'b0, 32'h8,         1'b0, '0, 0, 1'b0, 32'h11, 1'b0, 5});
    tbl.push_back('{1'b1, 32'h4,         1'b0, '0, 0, 1'b1, 32'h22, 1'b0, 6});
    tbl.push_back('{1'b1, 32'h1000,      1'b0, '0, 0, 1'b1, NOP,    1'b1, 7});
`ifdef INST_ROM_ALIGN_CHK_EN
    tbl.push_back('{1'b1, 32'h6,         1'b0, '0, 0, 1'b1, NOP,    1'b1, 8});
`else
    tbl.push_back('{1'b1, 32'h6,         1'b0, '0, 0, 1'b1, 32'h22, 1'b0, 8});
`endif
    tbl.push_back('{1'b1, 32'h1002,      1'b0, '0, 0, 1'b1, NOP,    1'b1, 9});
    tbl.push_back('{1'b1, 32'h8000_0000, 1'b0, '0, 0, 1'b1, NOP,    1'b1, 10});
    tbl.push_back('{1'b1, 32'hFFC,       1'b0, '0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 11});
    tbl.push_back('{1'b1, 32'h4,         1'b1, AW'(1), 32'h55, 1'b1, 32'h22, 1'b0, 12});
    tbl.push_back('{1'b1, 32'h4,         1'b0, '0, 0, 1'b1, 32'h55, 1'b0, 13});
`ifdef INST_ROM_ALIGN_CHK_EN
    tbl.push_back('{1'b1, 32'h7,         1'b0, '0, 0, 1'b1, NOP,    1'b1, 14});
`else
    tbl.push_back('{1'b1, 32'h7,         1'b0, '0, 0, 1'b1, 32'h55, 1'b0, 14});
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].a, tbl[i].w, tbl[i].la, tbl[i].ld);
      check($sformatf("tbl%0d_valid", i), v1, tbl[i].exp_v);
      check($sformatf("tbl%0d_data", i), d1, tbl[i].exp_d);
      if (tbl[i].exp_v) check($sformatf("tbl%0d_err", i), e1, tbl[i].exp_e);
      check($sformatf("tbl%0d_cnt", i), c1, tbl[i].exp_cnt);
    end

    // Three-edge latency: one fetch of word 2, then bubbles.
    step(1'b0, 32'd0); step(1'b0, 32'd0); step(1'b0, 32'd0);
    step(1'b1, 32'h8);
    check("lat3_edge_k", v3, 0);
    step(1'b0, 32'd0);
    check("lat3_edge_k1", v3, 0);
    step(1'b0, 32'd0);
    check("lat3_edge_k2_valid", v3, 1);
    check("lat3_edge_k2_data", d3, 32'h33);

    // Asynchronous reset with fetches in flight.
    step(1'b1, 32'h0); step(1'b1, 32'h4); step(1'b1, 32'h8);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_valid3", v3, 0);
    check("arst_data3", d3, NOP);
    check("arst_cnt3", c3, 0);
    check("arst_cnt1", c1, 0);
    step(1'b1, 32'hC);
    step(1'b1, 32'hC);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0);
      check("post_rst_no_valid3", v3, 0);
    end
    step(1'b1, 32'h8); step(1'b0, 32'h0); step(1'b0, 32'h0);
    check("post_rst_mem3", d3, 32'h33);
    check("post_rst_cnt3", c3, 1);

    // Randomised traffic with concurrent loads, checked against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom % 16 == 0) a = $urandom;
      else a = ($urandom % 16) * 4 + (($urandom % 8 == 0) ? ($urandom % 4) : 0);
      step(($urandom % 4) != 0, a, ($urandom % 5) == 0, AW'($urandom % 16), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
